// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite definitions for the compression IP register space.
// Response codes, width helper and byte-strobe merge.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int MAX_DW = 64;
    localparam int MAX_SW = MAX_DW / 8;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

    // Callers zero-extend narrower buses to the widest supported word.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_w,
        input logic [MAX_DW-1:0] new_w,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] r;
        r = old_w;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) begin
                r[b*8 +: 8] = new_w[b*8 +: 8];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_wr_join.sv
// Joins the AW and W channels in any arrival order.
// Holds one address and one data beat until the bank commits them.
module axi_lite_wr_join #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_done,
    input  logic [ADDR_W-1:0] awaddr,
    input  logic              awvalid,
    output logic              awready,
    input  logic [DATA_W-1:0] wdata,
    input  logic [STRB_W-1:0] wstrb,
    input  logic              wvalid,
    output logic              wready,
    input  logic              bvalid,
    output logic [ADDR_W-1:0] addr_q,
    output logic [DATA_W-1:0] data_q,
    output logic [STRB_W-1:0] strb_q,
    output logic              commit
);

    logic aw_held;
    logic w_held;

    assign awready = rst_done & ~aw_held;
    assign wready  = rst_done & ~w_held;
    // A pending response blocks the commit, never the acceptance.
    assign commit  = aw_held & w_held & ~bvalid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            addr_q  <= '0;
        end else if (awvalid && awready) begin
            aw_held <= 1'b1;
            addr_q  <= awaddr;
        end else if (commit) begin
            aw_held <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_held <= 1'b0;
            data_q <= '0;
            strb_q <= '0;
        end else if (wvalid && wready) begin
            w_held <= 1'b1;
            data_q <= wdata;
            strb_q <= wstrb;
        end else if (commit) begin
            w_held <= 1'b0;
        end
    end

endmodule

// File: rtl/axi_lite_regbank_p.sv
// Parametrised AXI4-Lite register bank for the compression IP.
// RW control registers, RO status registers, per-register write pulses.
module axi_lite_regbank_p
    import axi_lite_pkg::*;
#(
    parameter int                  DATA_W   = 32,
    parameter int                  ADDR_W   = 6,
    parameter int                  NUM_REGS = 4,
    parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [DATA_W-1:0]            S_AXI_WDATA,
    input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [DATA_W-1:0]            S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    output logic [NUM_REGS*DATA_W-1:0]   ctrl_out,
    input  logic [NUM_REGS*DATA_W-1:0]   sts_in,
    output logic [NUM_REGS-1:0]          wr_pulse
);

    localparam int STRB_W   = DATA_W / 8;
    localparam int ADDR_LSB = clog2(STRB_W);
    localparam int IDX_W    = ADDR_W - ADDR_LSB;

    logic                rst_done;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    logic [ADDR_W-1:0]   wr_addr;
    logic [DATA_W-1:0]   wr_data;
    logic [STRB_W-1:0]   wr_strb;
    logic                commit;

    logic [IDX_W-1:0]    wr_idx;
    logic [IDX_W-1:0]    rd_idx;
    logic [NUM_REGS-1:0] wr_sel;
    logic                wr_ok;
    logic [DATA_W-1:0]   wr_cur;
    logic [DATA_W-1:0]   wr_new;
    logic [MAX_DW-1:0]   old_ext;
    logic [MAX_DW-1:0]   new_ext;
    logic [MAX_SW-1:0]   strb_ext;
    logic [MAX_DW-1:0]   mrg;

    logic [DATA_W-1:0]   rd_val;
    logic                rd_ok;
    logic                ar_hs;

    logic                unused;

    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                      wr_addr[ADDR_LSB-1:0],
                      S_AXI_ARADDR[ADDR_LSB-1:0],
                      sts_in, mrg};

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rst_done <= 1'b0;
        end else begin
            rst_done <= 1'b1;
        end
    end

    axi_lite_wr_join #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .STRB_W (STRB_W)
    ) u_wr_join (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .rst_done (rst_done),
        .awaddr   (S_AXI_AWADDR),
        .awvalid  (S_AXI_AWVALID),
        .awready  (S_AXI_AWREADY),
        .wdata    (S_AXI_WDATA),
        .wstrb    (S_AXI_WSTRB),
        .wvalid   (S_AXI_WVALID),
        .wready   (S_AXI_WREADY),
        .bvalid   (S_AXI_BVALID),
        .addr_q   (wr_addr),
        .data_q   (wr_data),
        .strb_q   (wr_strb),
        .commit   (commit)
    );

    assign wr_idx = wr_addr[ADDR_W-1:ADDR_LSB];
    assign rd_idx = S_AXI_ARADDR[ADDR_W-1:ADDR_LSB];

    // Out-of-range and read-only targets leave wr_sel empty.
    always_comb begin
        wr_sel   = '0;
        wr_cur   = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_idx == IDX_W'(i)) begin
                wr_sel[i] = ~RO_MASK[i];
                wr_cur    = regs[i];
            end
        end
        wr_ok    = |wr_sel;
        old_ext  = '0;
        new_ext  = '0;
        strb_ext = '0;
        old_ext[DATA_W-1:0]  = wr_cur;
        new_ext[DATA_W-1:0]  = wr_data;
        strb_ext[STRB_W-1:0] = wr_strb;
        mrg      = strb_merge(old_ext, new_ext, strb_ext);
        wr_new   = mrg[DATA_W-1:0];
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_pulse <= '0;
        end else begin
            wr_pulse <= '0;
            if (commit) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (wr_sel[i]) begin
                        regs[i] <= wr_new;
                    end
                end
                wr_pulse <= wr_sel;
            end
        end
    end

    always_comb begin
        ctrl_out = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            ctrl_out[i*DATA_W +: DATA_W] = regs[i];
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= RESP_OKAY;
        end else if (commit) begin
            S_AXI_BVALID <= 1'b1;
            S_AXI_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_BVALID && S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
        end
    end

    always_comb begin
        rd_val = '0;
        rd_ok  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_ok  = 1'b1;
                rd_val = RO_MASK[i] ? sts_in[i*DATA_W +: DATA_W]
                                    : regs[i];
            end
        end
    end

    assign S_AXI_ARREADY = rst_done & ~S_AXI_RVALID;
    assign ar_hs         = S_AXI_ARVALID & S_AXI_ARREADY;

    // Sampling uses the pre-commit register value on a same-edge write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            S_AXI_RVALID <= 1'b0;
            S_AXI_RDATA  <= '0;
            S_AXI_RRESP  <= RESP_OKAY;
        end else if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RDATA  <= rd_val;
            S_AXI_RRESP  <= rd_ok ? RESP_OKAY : RESP_SLVERR;
        end else if (S_AXI_RVALID && S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_lite_regbank_p.sv
// Bench for axi_lite_regbank_p: cycle model plus directed literal checks.
// Four 32-bit registers, register 2 read-only.
module tb_axi_lite_regbank_p;
    import axi_lite_pkg::*;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NR = 4;
    localparam logic [NR-1:0] RO = 4'b0100;

    logic tb_ACLK = 1'b0;
    logic tb_ARESETN = 1'b1;

    logic [AW-1:0]    awaddr = '0;
    logic [2:0]       awprot = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [DW-1:0]    wdata = '0;
    logic [3:0]       wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b1;
    logic [AW-1:0]    araddr = '0;
    logic [2:0]       arprot = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b1;
    logic [NR*DW-1:0] ctrl_out;
    logic [NR*DW-1:0] sts_in;
    logic [NR-1:0]    wr_pulse;

    always #5 tb_ACLK = ~tb_ACLK;

    axi_lite_regbank_p #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_REGS (NR),
        .RO_MASK  (RO)
    ) dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (tb_ARESETN),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .ctrl_out      (ctrl_out),
        .sts_in        (sts_in),
        .wr_pulse      (wr_pulse)
    );

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;
    int pulse_cnt [NR] = '{0, 0, 0, 0};

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: pending address/data slots, response state.
    logic          m_rst_done = 1'b0;
    logic          m_aw_have = 1'b0;
    logic          m_w_have = 1'b0;
    logic [AW-1:0] m_aw_addr = '0;
    logic [DW-1:0] m_w_data = '0;
    logic [3:0]    m_w_strb = '0;
    logic          m_bvalid = 1'b0;
    logic [1:0]    m_bresp = '0;
    logic          m_rvalid = 1'b0;
    logic [DW-1:0] m_rdata = '0;
    logic [1:0]    m_rresp = '0;
    logic [DW-1:0] m_regs [NR];
    logic [NR-1:0] m_pulse = '0;

    always @(posedge tb_ACLK or negedge tb_ARESETN) begin
        if (!tb_ARESETN) begin
            m_rst_done = 1'b0;
            m_aw_have  = 1'b0;
            m_w_have   = 1'b0;
            m_bvalid   = 1'b0;
            m_bresp    = 2'b00;
            m_rvalid   = 1'b0;
            m_rdata    = '0;
            m_rresp    = 2'b00;
            m_pulse    = '0;
            for (int i = 0; i < NR; i++) m_regs[i] = '0;
        end else begin
            bit aw_hs;
            bit w_hs;
            bit ar_hs;
            bit cm;
            int widx;
            int ridx;
            aw_hs = awvalid && m_rst_done && !m_aw_have;
            w_hs  = wvalid && m_rst_done && !m_w_have;
            ar_hs = arvalid && m_rst_done && !m_rvalid;
            ridx  = int'(araddr >> 2);
            if (ar_hs) begin
                m_rvalid = 1'b1;
                if (ridx < NR) begin
                    m_rresp = 2'b00;
                    m_rdata = RO[ridx] ? sts_in[ridx*DW +: DW] : m_regs[ridx];
                end else begin
                    m_rresp = 2'b10;
                    m_rdata = '0;
                end
            end else if (m_rvalid && rready) begin
                m_rvalid = 1'b0;
            end
            m_pulse = '0;
            cm = m_aw_have && m_w_have && !m_bvalid;
            if (cm) begin
                widx = int'(m_aw_addr >> 2);
                if (widx < NR && !RO[widx]) begin
                    for (int b = 0; b < 4; b++)
                        if (m_w_strb[b]) m_regs[widx][b*8 +: 8] = m_w_data[b*8 +: 8];
                    m_pulse[widx] = 1'b1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
                m_bvalid  = 1'b1;
                m_aw_have = 1'b0;
                m_w_have  = 1'b0;
            end else if (m_bvalid && bready) begin
                m_bvalid = 1'b0;
            end
            if (aw_hs) begin
                m_aw_have = 1'b1;
                m_aw_addr = awaddr;
            end
            if (w_hs) begin
                m_w_have = 1'b1;
                m_w_data = wdata;
                m_w_strb = wstrb;
            end
            m_rst_done = 1'b1;
        end
    end

    always @(negedge tb_ACLK) begin
        if (chk_en) begin
            chk("awready", 64'(awready), 64'(m_rst_done && !m_aw_have));
            chk("wready", 64'(wready), 64'(m_rst_done && !m_w_have));
            chk("arready", 64'(arready), 64'(m_rst_done && !m_rvalid));
            chk("bvalid", 64'(bvalid), 64'(m_bvalid));
            if (m_bvalid || !tb_ARESETN)
                chk("bresp", 64'(bresp), 64'(m_bresp));
            chk("rvalid", 64'(rvalid), 64'(m_rvalid));
            if (m_rvalid || !tb_ARESETN) begin
                chk("rdata", 64'(rdata), 64'(m_rdata));
                chk("rresp", 64'(rresp), 64'(m_rresp));
            end
            chk("wr_pulse", 64'(wr_pulse), 64'(m_pulse));
            for (int i = 0; i < NR; i++)
                chk("ctrl_out", 64'(ctrl_out[i*DW +: DW]), 64'(m_regs[i]));
        end
        for (int i = 0; i < NR; i++)
            if (wr_pulse[i] === 1'b1) pulse_cnt[i]++;
    end

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int w_lead,
                            input bit take_b, output logic [1:0] resp);
        bit aw_done = 1'b0;
        bit w_done = 1'b0;
        bit aw_go;
        bit w_go;
        int cyc = 0;
        resp = 2'bxx;
        awaddr = a;
        wdata = d;
        wstrb = s;
        wvalid = 1'b1;
        if (w_lead == 0) awvalid = 1'b1;
        while (!(aw_done && w_done) && cyc < 50) begin
            aw_go = awvalid && awready;
            w_go = wvalid && wready;
            @(posedge tb_ACLK);
            #1;
            cyc++;
            if (aw_go) begin
                awvalid = 1'b0;
                aw_done = 1'b1;
            end
            if (w_go) begin
                wvalid = 1'b0;
                w_done = 1'b1;
            end
            if (!aw_done && cyc >= w_lead) awvalid = 1'b1;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        chk("wr_accept", 64'({aw_done, w_done}), 64'(2'b11));
        if (take_b) begin
            cyc = 0;
            while (!bvalid && cyc < 20) begin
                @(posedge tb_ACLK);
                #1;
                cyc++;
            end
            chk("b_latency", 64'(cyc), 64'(1));
            resp = bresp;
            @(posedge tb_ACLK);
            #1;
        end
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] r);
        bit go = 1'b0;
        int cyc = 0;
        araddr = a;
        arvalid = 1'b1;
        while (!go && cyc < 20) begin
            go = arready;
            @(posedge tb_ACLK);
            #1;
            cyc++;
        end
        arvalid = 1'b0;
        chk("ar_accept", 64'(go), 64'(1));
        chk("r_valid", 64'(rvalid), 64'(1));
        d = rdata;
        r = rresp;
        @(posedge tb_ACLK);
        #1;
    endtask

    logic [1:0]  resp;
    logic [DW-1:0] rd;

    initial begin
        sts_in = {32'h44444444, 32'hCAFEF00D, 32'h22222222, 32'h11111111};
        #1;
        tb_ARESETN = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1;
        chk("rst_ready", 64'({awready, wready, arready}), 64'(0));
        chk("rst_ctrl_lo", ctrl_out[63:0], 64'(0));
        chk("rst_ctrl_hi", ctrl_out[127:64], 64'(0));
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;
        chk("ready_up", 64'({awready, wready, arready}), 64'(3'b111));

        do_write(6'h00, 32'h0101FFFF, 4'hF, 0, 1'b1, resp);
        chk("w0_resp", 64'(resp), 64'(RESP_OKAY));
        do_write(6'h04, 32'habcd0001, 4'hF, 0, 1'b1, resp);
        chk("w1_resp", 64'(resp), 64'(RESP_OKAY));
        do_write(6'h08, 32'hdead0011, 4'hF, 0, 1'b1, resp);
        chk("w2_ro_resp", 64'(resp), 64'(RESP_SLVERR));
        do_write(6'h0C, 32'hbeef0011, 4'hF, 0, 1'b1, resp);
        chk("w3_resp", 64'(resp), 64'(RESP_OKAY));
        do_read(6'h00, rd, resp);
        chk("r0", 64'(rd), 64'(32'h0101FFFF));
        chk("r0_resp", 64'(resp), 64'(RESP_OKAY));
        do_read(6'h04, rd, resp);
        chk("r1", 64'(rd), 64'(32'habcd0001));
        do_read(6'h08, rd, resp);
        chk("r2_sts", 64'(rd), 64'(32'hCAFEF00D));
        do_read(6'h0C, rd, resp);
        chk("r3", 64'(rd), 64'(32'hbeef0011));
        chk("pulses0", 64'(pulse_cnt[0]), 64'(1));
        chk("pulses1", 64'(pulse_cnt[1]), 64'(1));
        chk("pulses2", 64'(pulse_cnt[2]), 64'(0));
        chk("pulses3", 64'(pulse_cnt[3]), 64'(1));

        do_write(6'h04, 32'h11223344, 4'b0101, 0, 1'b1, resp);
        chk("strb_resp", 64'(resp), 64'(RESP_OKAY));
        do_read(6'h06, rd, resp);
        chk("strb_merge", 64'(rd), 64'(32'hab220044));

        do_write(6'h0C, 32'hFFFFFFFF, 4'h0, 0, 1'b1, resp);
        chk("strb0_resp", 64'(resp), 64'(RESP_OKAY));
        chk("strb0_pulse", 64'(pulse_cnt[3]), 64'(2));
        do_read(6'h0C, rd, resp);
        chk("strb0_keep", 64'(rd), 64'(32'hbeef0011));

        do_write(6'h0C, 32'h00000000, 4'hF, 3, 1'b1, resp);
        chk("wfirst_resp", 64'(resp), 64'(RESP_OKAY));
        do_read(6'h0C, rd, resp);
        chk("wfirst_data", 64'(rd), 64'(0));
        do_write(6'h08, 32'h12345678, 4'hF, 0, 1'b1, resp);
        chk("same_ro_resp", 64'(resp), 64'(RESP_SLVERR));
        do_write(6'h00, 32'h12345678, 4'hF, 0, 1'b1, resp);
        do_read(6'h00, rd, resp);
        chk("same_data", 64'(rd), 64'(32'h12345678));

        do_write(6'h10, 32'h5A5A5A5A, 4'hF, 0, 1'b1, resp);
        chk("oob_wresp", 64'(resp), 64'(RESP_SLVERR));
        do_read(6'h3C, rd, resp);
        chk("oob_rdata", 64'(rd), 64'(0));
        chk("oob_rresp", 64'(resp), 64'(RESP_SLVERR));

        do_read(6'h08, rd, resp);
        chk("ro_rd", 64'(rd), 64'(32'hCAFEF00D));
        chk("ro_rresp", 64'(resp), 64'(RESP_OKAY));
        do_write(6'h08, 32'h0BADBEEF, 4'hF, 0, 1'b1, resp);
        chk("ro_wresp", 64'(resp), 64'(RESP_SLVERR));
        do_read(6'h08, rd, resp);
        chk("ro_rd2", 64'(rd), 64'(32'hCAFEF00D));

        bready = 1'b0;
        do_write(6'h04, 32'h600DF00D, 4'hF, 0, 1'b0, resp);
        repeat (2) @(posedge tb_ACLK);
        #1;
        chk("hold_bvalid", 64'(bvalid), 64'(1));
        awaddr = 6'h00;
        awvalid = 1'b1;
        wdata = 32'h77777777;
        wstrb = 4'hF;
        wvalid = 1'b1;
        repeat (10) @(posedge tb_ACLK);
        #1;
        chk("hold_bvalid2", 64'(bvalid), 64'(1));
        chk("hold_bresp", 64'(bresp), 64'(RESP_OKAY));
        chk("hold_no_commit", 64'(ctrl_out[31:0]), 64'(32'h12345678));
        chk("hold_latched", 64'({awready, wready}), 64'(0));
        #2;
        tb_ARESETN = 1'b0;
        #1;
        chk("mid_rst_b", 64'({bvalid, bresp}), 64'(0));
        chk("mid_rst_ctrl_lo", ctrl_out[63:0], 64'(0));
        chk("mid_rst_ctrl_hi", ctrl_out[127:64], 64'(0));
        chk("mid_rst_pulse", 64'(wr_pulse), 64'(0));
        awvalid = 1'b0;
        wvalid = 1'b0;
        bready = 1'b1;
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        @(posedge tb_ACLK);
        #1;
        do_read(6'h00, rd, resp);
        chk("post_rst_r0", 64'(rd), 64'(0));
        do_read(6'h04, rd, resp);
        chk("post_rst_r1", 64'(rd), 64'(0));
        repeat (3) @(posedge tb_ACLK);
        #1;
        chk("post_rst_idle", 64'({bvalid, rvalid, wr_pulse}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
